// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed byte stream (count, words, XOR checksum)
// and writes the words sequentially into instruction memory while holding the CPU in reset.
module imem_loader #(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        im_we,
  output logic [31:0] im_addr,
  output logic [31:0] im_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [8:0]  word_cnt
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] CNT_HI = 3'd1;
  localparam logic [2:0] CNT_LO = 3'd2;
  localparam logic [2:0] DATA   = 3'd3;
  localparam logic [2:0] WRITE  = 3'd4;
  localparam logic [2:0] CHK    = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;
  localparam logic [2:0] ERR    = 3'd7;

  localparam logic [16:0] DEPTH_N = 17'(DEPTH);

  logic [2:0]  state;
  logic [7:0]  cnt_hi;
  logic [15:0] n_q;
  logic [7:0]  chk_q;
  logic [1:0]  idx;
  logic [23:0] shift_q;

  logic        xfer;
  logic [15:0] n_new;
  logic [8:0]  wc_inc;

  assign xfer   = rx_valid && rx_ready;
  assign n_new  = {cnt_hi, rx_data};
  assign wc_inc = word_cnt + 9'd1;

  assign rx_ready = (state == CNT_HI) || (state == CNT_LO) || (state == DATA) || (state == CHK);
  assign im_we    = (state == WRITE);
  assign busy     = !((state == IDLE) || (state == DONE) || (state == ERR));
  assign done     = (state == DONE);
  assign err      = (state == ERR);
  // The CPU is released only once the checksum has matched.
  assign cpu_hold = (state != DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt_hi   <= '0;
      n_q      <= '0;
      chk_q    <= '0;
      idx      <= '0;
      shift_q  <= '0;
      im_addr  <= BASE_ADDR;
      im_wdata <= '0;
      word_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            state    <= CNT_HI;
            word_cnt <= '0;
            chk_q    <= '0;
            idx      <= '0;
          end
        end
        CNT_HI: begin
          if (xfer) begin
            cnt_hi <= rx_data;
            state  <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (xfer) begin
            n_q <= n_new;
            if (n_new == 16'd0)                 state <= CHK;
            else if ({1'b0, n_new} > DEPTH_N)   state <= ERR;
            else                                state <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            shift_q <= {shift_q[15:0], rx_data};
            chk_q   <= chk_q ^ rx_data;
            idx     <= idx + 2'd1;
            // Address/data are registered here so they hold steady after the strobe.
            if (idx == 2'd3) begin
              im_wdata <= {shift_q, rx_data};
              im_addr  <= BASE_ADDR + {21'd0, word_cnt, 2'b00};
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          word_cnt <= wc_inc;
          state    <= ({7'd0, wc_inc} == n_q) ? CHK : DATA;
        end
        CHK: begin
          if (xfer) state <= (rx_data == chk_q) ? DONE : ERR;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: receives a framed byte stream (e.g. from a UART receiver), assembles 32-bit instruction words, and writes them sequentially into a RAM-based instruction memory.
- Holds the CPU pipeline in reset until a complete image has been loaded and its checksum verified.
- Sits between the byte-stream source and the instruction memory write port.

Parameters:
- DEPTH, 256, number of 32-bit words in instruction memory; the memory indexes words by Address[9:2].
- BASE_ADDR, 32'h00000000, byte address of the first written word.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE and ERR.
- rx_valid  input  1  rx_data holds a valid byte.
- rx_data  input  8  stream byte.
- rx_ready  output  1  loader accepts a byte this cycle. Transfer occurs when rx_valid && rx_ready.
- im_we  output  1  instruction memory write strobe, one cycle per word.
- im_addr  output  32  byte address of the write; always word-aligned.
- im_wdata  output  32  instruction word to write.
- cpu_hold  output  1  high holds the CPU in reset.
- busy  output  1  high while a load is in progress.
- done  output  1  load completed and checksum matched.
- err  output  1  load aborted because of a bad count or a checksum mismatch.
- word_cnt  output  9  number of words written in the current load.

Behaviour:
- Frame format, in this order:
  - count_hi, count_lo: 16-bit big-endian word count N.
  - N words, 4 bytes each, MSB first. Bytes 3C 01 10 01 form 32'h3C011001.
  - chk: XOR of all data bytes only. The count bytes are excluded.
- Reset (async assert, sync deassert):
  - State goes to IDLE.
  - cpu_hold=1.
  - rx_ready, im_we, busy, done, err = 0.
  - im_addr=BASE_ADDR, im_wdata=0, word_cnt=0.
  - Internal checksum, byte index and shift register are cleared.
- States:
  - IDLE: rx_ready=0. On start: go to CNT_HI, set busy=1, clear word_cnt and checksum.
  - CNT_HI: rx_ready=1. On transfer: latch the high count byte, go to CNT_LO.
  - CNT_LO: rx_ready=1. On transfer, with N formed:
    - N==0: go to CHK.
    - N>DEPTH: go to ERR.
    - otherwise: go to DATA.
  - DATA: rx_ready=1. Each transfer shifts the byte into the word register and XORs it into the checksum. On the 4th byte, go to WRITE.
  - WRITE: rx_ready=0.
    - im_we=1 for exactly one cycle, with im_addr=BASE_ADDR+4*word_cnt and im_wdata=the assembled word.
    - word_cnt increments at the end of the cycle.
    - If the new word_cnt==N, go to CHK; otherwise go to DATA.
  - CHK: rx_ready=1. On transfer:
    - byte==checksum: go to DONE.
    - otherwise: go to ERR.
  - DONE: done=1, busy=0, cpu_hold=0, rx_ready=0.
  - ERR: err=1, busy=0, cpu_hold=1, rx_ready=0.
  - From DONE or ERR, start restarts the load: go to CNT_HI, clear done and err, set cpu_hold=1.
- Latency: im_we asserts in the cycle after the 4th byte of a word is accepted. At most one byte is accepted per cycle.
- cpu_hold rises in the same cycle the restart transition registers; it never drops before the checksum is verified.
- start pulses in CNT_HI, CNT_LO, DATA, WRITE or CHK are ignored.
- rx_valid while rx_ready=0: the byte is not consumed. The source must hold the byte.
- Gaps in rx_valid stall the FSM without losing state.
- Memory already written is not rolled back on ERR.
- Reset asserted mid-load aborts immediately; no further im_we pulses occur.
- im_addr and im_wdata hold their last values when im_we=0.

Test Plan:
- Reset → cpu_hold=1, rx_ready=im_we=busy=done=err=0, word_cnt=0, im_addr=0.
- Two-word load: start, bytes 00 02 3C 01 10 01 34 24 00 00 3C → writes (0x00, 3C011001) and (0x04, 34240000), one im_we cycle each. Then done=1, cpu_hold=0, word_cnt=2.
- Same frame with final byte 3D → both words written, then err=1, done=0, cpu_hold=1, rx_ready=0. A following start restarts the load with err cleared.
- Count bytes 01 01 (N=257) → err=1 directly after count_lo, zero im_we pulses.
- Full load of N=256 with random rx_valid gaps and rx_valid held high during WRITE cycles → no byte lost or duplicated, last write at im_addr=0x3FC, done=1. Separately, N=0 with chk 00 → done=1 with no writes.
- Reset asserted after 2 bytes of word 1 → im_we never pulses again, cpu_hold=1, state IDLE. A subsequent start plus a valid frame loads correctly.
